sample_cache: RTL and testbench



---
 rtl/sample_cache.sv | 104 ++++++++++
 tb/tb_sample_cache.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sample_cache.sv
// Sample packer: keeps the bytes of the active channel groups and packs them
// densely into memory words, exposing the partial word for cache transmission.
module sample_cache #(
    parameter int WIDTH = 32,
    localparam int L    = WIDTH / 8,
    localparam int FW   = (L > 1) ? $clog2(L) : 1,
    localparam int SW   = $clog2(2 * L) + 1
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             stb_i,
    input  logic [WIDTH-1:0] smpls_i,
    input  logic [L-1:0]     cfg_i,
    input  logic             clr_i,
    output logic             cstb_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] cache_o,
    output logic [FW-1:0]    fill_o
);

    // stb_i qualifies smpls_i for exactly one cycle. There is no ready: every
    // sample is accepted, since one sample completes at most one word.

    logic [WIDTH-1:0]   cache;
    logic [WIDTH-1:0]   q;
    logic [FW-1:0]      fill;
    logic [L-1:0]       cfg_q;
    logic               cstb;

    logic               cfg_change;
    logic [WIDTH-1:0]   comp;
    logic [SW-1:0]      n;
    logic [FW-1:0]      base_fill;
    logic [WIDTH-1:0]   base_cache;
    logic [2*WIDTH-1:0] win;
    logic [SW-1:0]      s;
    logic [SW-1:0]      rest;
    logic               done;

    assign cfg_change = (cfg_i != cfg_q);

    // A configuration change starts from an empty cache so words never mix widths.
    assign base_fill  = cfg_change ? '0 : fill;
    assign base_cache = cfg_change ? '0 : cache;

    always_comb begin
        comp = '0;
        n    = '0;
        // Walk lanes from the top so the lowest active lane lands in byte 0.
        for (int g = L - 1; g >= 0; g--) begin
            if (cfg_i[g]) begin
                comp      = comp << 8;
                comp[7:0] = smpls_i[g*8 +: 8];
                n         = n + SW'(1);
            end
        end
    end

    always_comb begin
        win  = ({{WIDTH{1'b0}}, comp} << {base_fill, 3'b000})
             | {{WIDTH{1'b0}}, base_cache};
        s    = SW'(base_fill) + n;
        done = (s >= SW'(L));
        rest = s - SW'(L);
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cache <= '0;
            q     <= '0;
            fill  <= '0;
            cfg_q <= '0;
            cstb  <= 1'b0;
        end else begin
            cstb <= 1'b0;
            if (cfg_change) begin
                cfg_q <= cfg_i;
            end
            if (clr_i) begin
                cache <= '0;
                fill  <= '0;
            end else if (stb_i && (n != '0)) begin
                if (done) begin
                    q     <= win[WIDTH-1:0];
                    cache <= win[2*WIDTH-1:WIDTH];
                    fill  <= rest[FW-1:0];
                    cstb  <= 1'b1;
                end else begin
                    cache <= win[WIDTH-1:0];
                    fill  <= s[FW-1:0];
                end
            end else if (cfg_change) begin
                cache <= '0;
                fill  <= '0;
            end
        end
    end

    assign cstb_o  = cstb;
    assign q_o     = q;
    assign cache_o = cache;
    assign fill_o  = fill;

endmodule

// File: tb/tb_sample_cache.sv
// Randomized bench for sample_cache against a byte-queue reference model,
// preceded by the directed packing, flush and reset scenarios.
module tb_sample_cache;

    localparam int W = 32;
    localparam int L = W / 8;

    logic         clk_i;
    logic         rst_in;
    logic         stb_i;
    logic [W-1:0] smpls_i;
    logic [L-1:0] cfg_i;
    logic         clr_i;
    logic         cstb_o;
    logic [W-1:0] q_o;
    logic [W-1:0] cache_o;
    logic [1:0]   fill_o;

    sample_cache #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_in  (rst_in),
        .stb_i   (stb_i),
        .smpls_i (smpls_i),
        .cfg_i   (cfg_i),
        .clr_i   (clr_i),
        .cstb_o  (cstb_o),
        .q_o     (q_o),
        .cache_o (cache_o),
        .fill_o  (fill_o)
    );

    // clock / reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int checks = 0;
    int errors = 0;

    // reference model: pending bytes in arrival order, completed words in order
    logic [7:0]   byte_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_q;
    logic         m_cstb;
    logic [L-1:0] m_cfg;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        byte_q.delete();
        exp_q.delete();
        m_q    = '0;
        m_cstb = 1'b0;
        m_cfg  = '0;
    endtask

    task automatic model_apply(input logic stb, input logic [W-1:0] smp,
                               input logic [L-1:0] cfg, input logic clr);
        logic [W-1:0] w;
        m_cstb = 1'b0;
        if (clr) begin
            byte_q.delete();
        end else begin
            if (cfg != m_cfg) byte_q.delete();
            if (stb) begin
                for (int g = 0; g < L; g++)
                    if (cfg[g]) byte_q.push_back(smp[g*8 +: 8]);
            end
            if (byte_q.size() >= L) begin
                w = '0;
                for (int i = 0; i < L; i++) w[i*8 +: 8] = byte_q.pop_front();
                m_q    = w;
                m_cstb = 1'b1;
                exp_q.push_back(w);
            end
        end
        m_cfg = cfg;
    endtask

    task automatic compare_all();
        logic [W-1:0] exp_cache;
        exp_cache = '0;
        for (int i = 0; i < byte_q.size(); i++) exp_cache[i*8 +: 8] = byte_q[i];
        check("cstb", W'(cstb_o), W'(m_cstb));
        check("q", q_o, m_q);
        check("cache", cache_o, exp_cache);
        check("fill", W'(fill_o), W'(byte_q.size()));
        if (cstb_o) begin
            if (exp_q.size() == 0) check("word_unexpected", q_o, 'x);
            else check("word", q_o, exp_q.pop_front());
        end
    endtask

    // driver: apply one cycle of inputs, then check one step after the edge
    task automatic step(input logic stb, input logic [W-1:0] smp,
                        input logic [L-1:0] cfg, input logic clr);
        stb_i   = stb;
        smpls_i = smp;
        cfg_i   = cfg;
        clr_i   = clr;
        @(posedge clk_i);
        model_apply(stb, smp, cfg, clr);
        #1;
        compare_all();
        stb_i = 1'b0;
        clr_i = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_hi(input logic [7:0] lo);
        logic [W-1:0] v;
        v      = $urandom;
        v[7:0] = lo;
        return v;
    endfunction

    initial begin
        logic [L-1:0] cfg;
        rst_in  = 1'b0;
        stb_i   = 1'b0;
        smpls_i = '0;
        cfg_i   = '0;
        clr_i   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        compare_all();
        rst_in = 1'b1;

        // full-width sample completes a word at once
        step(1'b1, 32'hDDCCBBAA, 4'b1111, 1'b0);
        check("plan1_q", q_o, 32'hDDCCBBAA);
        check("plan1_cstb", W'(cstb_o), 32'h1);
        step(1'b0, 32'h0, 4'b1111, 1'b0);
        check("plan1_cstb_drop", W'(cstb_o), 32'h0);

        // single group, upper lanes must be ignored
        step(1'b1, rnd_hi(8'h11), 4'b0001, 1'b0);
        step(1'b1, rnd_hi(8'h22), 4'b0001, 1'b0);
        step(1'b1, rnd_hi(8'h33), 4'b0001, 1'b0);
        check("plan2_cache", cache_o, 32'h00332211);
        check("plan2_fill3", W'(fill_o), 32'h3);
        step(1'b1, rnd_hi(8'h44), 4'b0001, 1'b0);
        check("plan2_q", q_o, 32'h44332211);

        // three groups, carry into the next word
        step(1'b1, 32'h00332211, 4'b0111, 1'b0);
        step(1'b1, 32'h00665544, 4'b0111, 1'b0);
        check("plan3_q", q_o, 32'h44332211);
        check("plan3_cache", cache_o, 32'h00006655);
        check("plan3_fill", W'(fill_o), 32'h2);

        // sparse groups, then a cfg change in the same cycle as a sample
        step(1'b1, 32'h00CC00AA, 4'b0101, 1'b0);
        step(1'b1, 32'h00DD00BB, 4'b0101, 1'b0);
        check("plan4_q", q_o, 32'hDDBBCCAA);
        step(1'b1, 32'h00770066, 4'b0101, 1'b0);
        step(1'b1, 32'h000000EE, 4'b0001, 1'b0);
        check("plan4_cache", cache_o, 32'h000000EE);
        check("plan4_cstb", W'(cstb_o), 32'h0);

        // clear beats a sample and a cfg change; cfg 0 is a no-op
        step(1'b1, 32'h000000FF, 4'b0001, 1'b0);
        step(1'b1, 32'h01020304, 4'b1111, 1'b1);
        check("plan5_q_held", q_o, 32'hDDBBCCAA);
        check("plan5_fill", W'(fill_o), 32'h0);
        step(1'b1, 32'h55555555, 4'b0000, 1'b0);

        // asynchronous reset between edges with a partial word
        step(1'b1, 32'h00030201, 4'b0111, 1'b0);
        #2 rst_in = 1'b0;
        #1;
        model_reset();
        compare_all();
        #2 rst_in = 1'b1;
        step(1'b1, 32'h12345678, 4'b1111, 1'b0);
        check("plan6_q", q_o, 32'h12345678);

        // randomized traffic
        cfg = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) cfg = L'($urandom_range(0, 15));
            step(($urandom_range(0, 9) < 7), $urandom, cfg, ($urandom_range(0, 24) == 0));
        end

        check("words_left", W'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
